// File: rtl/vec_issue_ctrl_pkg.sv
// rtl/vec_issue_ctrl_pkg.sv - shared state encoding and vector geometry for the vector issue controller
package vec_issue_ctrl_pkg;

  localparam int LANE_W = 16;
  localparam int LANES  = 16;
  localparam int VW_DEF = LANE_W * LANES;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/vec_issue_timer.sv
// rtl/vec_issue_timer.sv - loadable saturating up-counter with clear and terminal-count flag
module vec_issue_timer #(
  parameter int W  = 4,
  parameter int TC = 15
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  // Terminal count is sticky: the counter parks at TC so a long hold never wraps back below it.
  assign tc = (count >= W'(TC));

  // Clear wins over load, load wins over counting.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !tc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/vec_issue_ctrl.sv
// rtl/vec_issue_ctrl.sv - start/done initiator for the 16-lane vector unit; optional VEC_ISSUE_STATS_EN adds op counters
module vec_issue_ctrl
  import vec_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT  = 16,
  parameter int IDLE_CYC = 2,
  parameter int VW       = VW_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [VW-1:0] cmd_a,
  input  logic [VW-1:0] cmd_b,
  output logic [VW-1:0] VecA,
  output logic [VW-1:0] VecB,
  output logic          start,
  input  logic          done,
  input  logic [VW-1:0] SumV,
  input  logic          V,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [VW-1:0] res_data,
  output logic          res_ovf,
  output logic          res_timeout
`ifdef VEC_ISSUE_STATS_EN
  ,
  output logic [15:0]   stat_ops,
  output logic [15:0]   stat_ovf,
  output logic [7:0]    stat_tmo
`endif
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RW = $clog2(IDLE_CYC + 1);

  state_t state, state_n;
  logic   accept, cap_done, cap_tmo, release_res;
  logic   tmo_tc, rec_tc;

  // Ready depends on state alone; reset holds it low.
  assign cmd_ready = (state == ST_IDLE) && !Rst;

  // Timeout counter: restarted on acceptance, counts every BUSY cycle.
  vec_issue_timer #(.W(TW), .TC(TIMEOUT - 1)) u_tmo (
    .clk      (Clk),
    .clear    (Rst),
    .load     (accept),
    .load_val ('0),
    .en       (state == ST_BUSY),
    .tc       (tmo_tc)
  );

  // Recovery counter: restarted on RESP entry so a held result counts toward the start-low gap.
  vec_issue_timer #(.W(RW), .TC(IDLE_CYC)) u_rec (
    .clk      (Clk),
    .clear    (Rst),
    .load     (cap_done || cap_tmo),
    .load_val ('0),
    .en       ((state == ST_RESP) || (state == ST_RECOVER)),
    .tc       (rec_tc)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath strobes; done outside BUSY/RECOVER exit checks is ignored.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    cap_done    = 1'b0;
    cap_tmo     = 1'b0;
    release_res = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) begin
          cap_done = 1'b1;
          state_n  = ST_RESP;
        end else if (tmo_tc) begin
          cap_tmo = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          release_res = 1'b1;
          state_n     = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (rec_tc && !done) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Operand, start and result registers; each only moves on its own strobe.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      VecA        <= '0;
      VecB        <= '0;
      start       <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_ovf     <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (accept) begin
        VecA  <= cmd_a;
        VecB  <= cmd_b;
        start <= 1'b1;
      end
      if (cap_done) begin
        res_data    <= SumV;
        res_ovf     <= V;
        res_timeout <= 1'b0;
        res_valid   <= 1'b1;
        start       <= 1'b0;
      end
      if (cap_tmo) begin
        res_data    <= '0;
        res_ovf     <= 1'b0;
        res_timeout <= 1'b1;
        res_valid   <= 1'b1;
        start       <= 1'b0;
      end
      if (release_res) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef VEC_ISSUE_STATS_EN
  // Operation statistics, bumped on the RESP-entry cycle and wrapping at their width.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stat_ops <= '0;
      stat_ovf <= '0;
      stat_tmo <= '0;
    end else begin
      if (cap_done) begin
        stat_ops <= stat_ops + 16'd1;
      end
      if (cap_done && V) begin
        stat_ovf <= stat_ovf + 16'd1;
      end
      if (cap_tmo) begin
        stat_tmo <= stat_tmo + 8'd1;
      end
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// tb/tb_vec_issue_ctrl.sv - randomized self-checking bench for vec_issue_ctrl with a behavioural vector-unit model
module tb_vec_issue_ctrl;

  localparam int VW       = 256;
  localparam int TIMEOUT  = 16;
  localparam int IDLE_CYC = 2;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [VW-1:0] cmd_a = '0;
  logic [VW-1:0] cmd_b = '0;
  logic [VW-1:0] VecA, VecB;
  logic          start;
  logic          done;
  logic [VW-1:0] SumV;
  logic          V;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [VW-1:0] res_data;
  logic          res_ovf;
  logic          res_timeout;
`ifdef VEC_ISSUE_STATS_EN
  logic [15:0]   stat_ops, stat_ovf;
  logic [7:0]    stat_tmo;
`endif

  int total = 0;
  int bad   = 0;

  vec_issue_ctrl #(.TIMEOUT(TIMEOUT), .IDLE_CYC(IDLE_CYC), .VW(VW)) dut (
    .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .VecA(VecA), .VecB(VecB), .start(start),
    .done(done), .SumV(SumV), .V(V), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .res_timeout(res_timeout)
`ifdef VEC_ISSUE_STATS_EN
    , .stat_ops(stat_ops), .stat_ovf(stat_ovf), .stat_tmo(stat_tmo)
`endif
  );

  always #5 Clk = ~Clk;

  // Vector-unit model: done rises once start has been seen high unit_lat times, and falls
  // unit_hold cycles after start drops.
  int            unit_lat   = 4;
  int            unit_hold  = 0;
  logic          unit_never = 1'b0;
  logic [VW-1:0] unit_sum   = '0;
  logic          unit_v     = 1'b0;
  logic          force_done = 1'b0;
  logic          done_m     = 1'b0;
  int            scnt = 0;
  int            hcnt = 0;

  always @(posedge Clk) begin
    #2;
    if (Rst) begin
      scnt = 0; hcnt = 0; done_m = 1'b0;
    end else if (start) begin
      hcnt = 0;
      scnt = scnt + 1;
      if (!unit_never && scnt >= unit_lat) done_m = 1'b1;
    end else begin
      scnt = 0;
      if (done_m) begin
        hcnt = hcnt + 1;
        if (hcnt > unit_hold) done_m = 1'b0;
      end
    end
  end

  assign done = done_m | force_done;
  assign SumV = done ? unit_sum : ~unit_sum;
  assign V    = done ? unit_v : ~unit_v;

  typedef struct {
    logic [VW-1:0] d;
    logic          o;
    logic          t;
    int            slen;
  } exp_t;
  exp_t q[$];

  function automatic logic [VW-1:0] rnd256();
    logic [VW-1:0] r;
    for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Expected outcome from the unit settings: a unit slower than TIMEOUT looks like no done at all.
  function automatic exp_t predict();
    exp_t e;
    if (unit_never || unit_lat > TIMEOUT) begin
      e.d = '0; e.o = 1'b0; e.t = 1'b1; e.slen = TIMEOUT;
    end else begin
      e.d = unit_sum; e.o = unit_v; e.t = 1'b0; e.slen = unit_lat;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit keep_valid);
    int w;
    w = 0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
    while (!cmd_ready && w < 50) begin step(); w++; end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL issue_wait cmd_ready=%0b required 1", cmd_ready);
    end
    step();
    q.push_back(predict());
    if (!keep_valid) begin
      cmd_valid = 1'b0; cmd_a = rnd256(); cmd_b = rnd256();
    end
    total++;
    if (VecA !== a || VecB !== b || start !== 1'b1) begin
      bad++; $display("FAIL issue_latch VecA=%h VecB=%h start=%0b required %h %h 1", VecA, VecB, start, a, b);
    end
  endtask

  // Drains the op in flight: checks start duration, result, hold behaviour and release.
  task automatic finish_op(input int hold);
    exp_t          e;
    int            n;
    logic [VW-1:0] va, held;
    n  = 0;
    va = VecA;
    while (start && n < 100) begin
      if (!cmd_valid) begin cmd_a = rnd256(); cmd_b = rnd256(); end
      step(); n++;
    end
    if (q.size() == 0) begin
      total++; bad++; $display("FAIL finish_noexp queue=0 required 1");
      return;
    end
    e = q.pop_front();
    total++;
    if (VecA !== va) begin
      bad++; $display("FAIL operand_stable VecA=%h required %h", VecA, va);
    end
    total++;
    if (n !== e.slen) begin
      bad++; $display("FAIL start_len got=%0d required %0d", n, e.slen);
    end
    total++;
    if (res_valid !== 1'b1 || res_data !== e.d || res_ovf !== e.o || res_timeout !== e.t) begin
      bad++;
      $display("FAIL result valid=%0b ovf=%0b tmo=%0b data=%h required 1 %0b %0b %h",
               res_valid, res_ovf, res_timeout, res_data, e.o, e.t, e.d);
    end
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      step();
      total++;
      if (res_valid !== 1'b1 || res_data !== held || start !== 1'b0 || cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL result_hold valid=%0b start=%0b cmd_ready=%0b data=%h required 1 0 0 %h",
                 res_valid, start, cmd_ready, res_data, held);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0) begin
      bad++; $display("FAIL result_release res_valid=%0b required 0", res_valid);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step(); step();
    total++;
    if (start !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b0 || res_data !== '0 ||
        res_ovf !== 1'b0 || res_timeout !== 1'b0 || VecA !== '0 || VecB !== '0) begin
      bad++;
      $display("FAIL reset_state start=%0b res_valid=%0b cmd_ready=%0b ovf=%0b tmo=%0b required all 0",
               start, res_valid, cmd_ready, res_ovf, res_timeout);
    end
    Rst = 1'b0;
    step();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_idle cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    unit_lat = 4; unit_never = 1'b0; unit_hold = 0;
    unit_sum = {16{16'h3c00}}; unit_v = 1'b0;
    issue({16{16'h3c00}}, '0, 1'b0);
    finish_op(0);
  endtask

  task automatic test_overflow();
    unit_lat = 4; unit_sum = {16{16'h7c00}}; unit_v = 1'b1;
    issue({16{16'h7cde}}, '0, 1'b0);
    finish_op(0);
  endtask

  task automatic test_timeout();
    unit_never = 1'b1; unit_sum = rnd256(); unit_v = 1'b1;
    issue(rnd256(), rnd256(), 1'b0);
    finish_op(0);
    unit_never = 1'b0; unit_lat = 3; unit_sum = rnd256(); unit_v = 1'b0;
    issue(rnd256(), rnd256(), 1'b0);
    finish_op(1);
  endtask

  // done arriving exactly on the last allowed cycle wins; one cycle later is a timeout.
  task automatic test_done_tmo_tie();
    unit_lat = TIMEOUT; unit_sum = rnd256(); unit_v = 1'b1;
    issue(rnd256(), rnd256(), 1'b0);
    finish_op(0);
    unit_lat = TIMEOUT + 1; unit_sum = rnd256();
    issue(rnd256(), rnd256(), 1'b0);
    finish_op(0);
  endtask

  task automatic test_held_result();
    logic [VW-1:0] a2, b2;
    int            n, hold, expn, gap;
    hold = 10;
    unit_lat = 4; unit_sum = rnd256(); unit_v = 1'b0;
    issue(rnd256(), rnd256(), 1'b1);
    a2 = rnd256(); b2 = rnd256();
    cmd_a = a2; cmd_b = b2;
    finish_op(hold);
    // Recovery count started at RESP entry, so after a long hold only the RECOVER visit remains.
    gap  = IDLE_CYC - (hold + 1) + 1;
    expn = 1 + ((gap > 1) ? gap : 1);
    unit_sum = rnd256(); unit_v = 1'b1;
    n = 0;
    while (!start && n < 30) begin step(); n++; end
    q.push_back(predict());
    cmd_valid = 1'b0;
    total++;
    if (n !== expn) begin
      bad++; $display("FAIL held_restart edges=%0d required %0d", n, expn);
    end
    total++;
    if (VecA !== a2 || VecB !== b2) begin
      bad++; $display("FAIL held_operands VecA=%h required %h", VecA, a2);
    end
    finish_op(0);
  endtask

  task automatic test_reset_busy();
    unit_lat = 6; unit_sum = rnd256(); unit_v = 1'b1;
    issue(rnd256(), rnd256(), 1'b0);
    step(); step();
    Rst = 1'b1;
    step();
    void'(q.pop_front());
    total++;
    if (start !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b0 || VecA !== '0) begin
      bad++;
      $display("FAIL reset_busy start=%0b res_valid=%0b cmd_ready=%0b required 0 0 0", start, res_valid, cmd_ready);
    end
    Rst = 1'b0;
    step();
    total++;
    if (cmd_ready !== 1'b1 || start !== 1'b0) begin
      bad++; $display("FAIL reset_busy_idle cmd_ready=%0b start=%0b required 1 0", cmd_ready, start);
    end
    force_done = 1'b1;
    step(); step();
    force_done = 1'b0;
    step();
    total++;
    if (res_valid !== 1'b0 || res_data !== '0 || res_ovf !== 1'b0 || start !== 1'b0) begin
      bad++; $display("FAIL late_done res_valid=%0b ovf=%0b data=%h required 0 0 0", res_valid, res_ovf, res_data);
    end
  endtask

  task automatic test_done_stuck();
    int n;
    unit_lat = 4; unit_hold = 5; unit_sum = rnd256(); unit_v = 1'b0;
    issue(rnd256(), rnd256(), 1'b0);
    finish_op(0);
    n = 0;
    while (done && n < 40) begin
      total++;
      if (cmd_ready !== 1'b0 || start !== 1'b0) begin
        bad++; $display("FAIL stuck_recover cmd_ready=%0b start=%0b required 0 0", cmd_ready, start);
      end
      step(); n++;
    end
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL stuck_release done=%0b cmd_ready=%0b required 0 1", done, cmd_ready);
    end
    unit_hold = 0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      unit_lat   = $urandom_range(1, 10);
      unit_never = ($urandom_range(0, 5) == 0);
      unit_sum   = rnd256();
      unit_v     = 1'($urandom_range(0, 1));
      issue(rnd256(), rnd256(), 1'b0);
      finish_op($urandom_range(0, 4));
    end
    unit_never = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_timeout();
    test_done_tmo_tie();
    test_held_result();
    test_reset_busy();
    test_done_stuck();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
